// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard FIFO: register map, STATUS bit
// positions, receive FSM states and the hex-digit segment decoder.
package ps2_kbd_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_LEVEL  = 2'd2;
    localparam logic [1:0] ADDR_LAST   = 2'd3;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_PERR      = 3;
    localparam int ST_FERR      = 4;
    localparam int ST_IRQ_EN    = 7;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Hex digit to 7-segment pattern, segments {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the keyboard pins, debounces the clock
// line, deframes 11-bit frames and reports good bytes or errors as pulses.
import ps2_kbd_pkg::*;

module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_resetN,
    input  logic       i_kc,
    input  logic       i_kd,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_perr,
    output logic       o_ferr
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]     r_kcSync;
    logic [1:0]     r_kdSync;
    logic           r_kcFilt;
    logic           r_kcFiltDly;
    logic [FCW-1:0] r_filtCnt;
    rx_state_t      r_state;
    rx_state_t      w_nextState;
    logic [2:0]     r_bitCnt;
    logic [7:0]     r_shift;
    logic           r_parityBit;
    logic [TCW-1:0] r_idleCnt;
    logic           w_strobe;
    logic           w_kd;
    logic           w_timeout;
    logic           w_good;
    logic           w_badParity;
    logic           w_badStop;

    assign w_kd      = r_kdSync[1];
    assign w_strobe  = r_kcFiltDly & ~r_kcFilt;
    assign w_timeout = (r_state != RX_IDLE) && !w_strobe &&
                       (r_idleCnt == TCW'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronisers for the asynchronous pins; idle level is high
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_kcSync <= 2'b11;
            r_kdSync <= 2'b11;
        end else begin
            r_kcSync <= {r_kcSync[0], i_kc};
            r_kdSync <= {r_kdSync[0], i_kd};
        end
    end

    // Clock filter: output follows kc only after FILTER_LEN differing samples in a row
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_kcFilt    <= 1'b1;
            r_kcFiltDly <= 1'b1;
            r_filtCnt   <= '0;
        end else begin
            r_kcFiltDly <= r_kcFilt;
            if (r_kcSync[1] == r_kcFilt) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FCW'(FILTER_LEN - 1)) begin
                r_kcFilt  <= r_kcSync[1];
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + FCW'(1);
            end
        end
    end

    // Receive FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Receive FSM next state and end-of-frame verdict
    always_comb begin
        w_nextState = r_state;
        w_good      = 1'b0;
        w_badParity = 1'b0;
        w_badStop   = 1'b0;
        if (w_timeout) begin
            w_nextState = RX_IDLE;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_strobe && !w_kd) begin
                        w_nextState = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_strobe && (r_bitCnt == 3'd7)) begin
                        w_nextState = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (w_strobe) begin
                        w_nextState = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_strobe) begin
                        w_nextState = RX_IDLE;
                        w_badStop   = !w_kd;
                        w_badParity = !(^{r_shift, r_parityBit});
                        w_good      = w_kd && (^{r_shift, r_parityBit});
                    end
                end
                default: w_nextState = RX_IDLE;
            endcase
        end
    end

    // Frame datapath: bit shifter, bit counter, parity capture and idle timer
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parityBit <= 1'b0;
            r_idleCnt   <= '0;
        end else begin
            if ((r_state == RX_IDLE) || w_strobe) begin
                r_idleCnt <= '0;
            end else begin
                r_idleCnt <= r_idleCnt + TCW'(1);
            end
            if (r_state == RX_IDLE) begin
                r_bitCnt <= '0;
            end else if ((r_state == RX_DATA) && w_strobe) begin
                r_shift  <= {w_kd, r_shift[7:1]};
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            if ((r_state == RX_PARITY) && w_strobe) begin
                r_parityBit <= w_kd;
            end
        end
    end

    // Registered result pulses towards the FIFO and status flags
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            o_byte  <= '0;
            o_valid <= 1'b0;
            o_perr  <= 1'b0;
            o_ferr  <= 1'b0;
        end else begin
            o_valid <= w_good;
            o_perr  <= w_badParity;
            o_ferr  <= w_badStop | w_timeout;
            if (w_good) begin
                o_byte <= r_shift;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard Avalon-MM slave: scancode FIFO, status/irq registers and a
// two-digit display of the most recent good scancode.
import ps2_kbd_pkg::*;

module ps2_keyboard_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       csi_clk,
    input  logic       csi_reset_n,
    input  logic [1:0] avs_s1_address,
    input  logic       avs_s1_read,
    output logic [7:0] avs_s1_readdata,
    input  logic       avs_s1_write,
    input  logic [7:0] avs_s1_writedata,
    output logic       ins_irq0_irq,
    input  logic       coe_kc,
    input  logic       coe_kd,
    output logic [6:0] coe_sseg0,
    output logic [6:0] coe_sseg1
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    w_rxByte;
    logic          w_rxValid;
    logic          w_rxPerr;
    logic          w_rxFerr;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_perr;
    logic          r_ferr;
    logic          r_irqEn;
    logic [7:0]    r_last;
    logic [7:0]    r_readData;
    logic          r_irq;
    logic          w_notEmpty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_statusWr;
    logic [7:0]    w_status;
    logic [8:0]    w_count9;
    logic [7:0]    w_level;
    logic          w_unusedWdata;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk    (csi_clk),
        .i_resetN (csi_reset_n),
        .i_kc     (coe_kc),
        .i_kd     (coe_kd),
        .o_byte   (w_rxByte),
        .o_valid  (w_rxValid),
        .o_perr   (w_rxPerr),
        .o_ferr   (w_rxFerr)
    );

    assign w_notEmpty    = (r_count != '0);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_pop         = avs_s1_read && (avs_s1_address == ADDR_DATA) && w_notEmpty;
    assign w_push        = w_rxValid && (!w_full || w_pop);
    assign w_drop        = w_rxValid && w_full && !w_pop;
    assign w_statusWr    = avs_s1_write && (avs_s1_address == ADDR_STATUS);
    assign w_count9      = 9'(r_count);
    assign w_level       = (w_count9 > 9'd255) ? 8'hFF : w_count9[7:0];
    assign w_unusedWdata = ^{avs_s1_writedata[6:5], avs_s1_writedata[1:0]};

    // Assemble the STATUS view from the live FIFO state and sticky flags
    always_comb begin
        w_status               = '0;
        w_status[ST_NOT_EMPTY] = w_notEmpty;
        w_status[ST_FULL]      = w_full;
        w_status[ST_OVF]       = r_ovf;
        w_status[ST_PERR]      = r_perr;
        w_status[ST_FERR]      = r_ferr;
        w_status[ST_IRQ_EN]    = r_irqEn;
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge csi_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_rxByte;
        end
    end

    // FIFO pointers and level; simultaneous push and pop leaves the level alone
    always_ff @(posedge csi_clk) begin
        if (!csi_reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky error flags (a new event beats a same-cycle clear) and irq enable
    always_ff @(posedge csi_clk) begin
        if (!csi_reset_n) begin
            r_ovf   <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_irqEn <= 1'b0;
        end else begin
            r_ovf  <= w_drop   | (r_ovf  & ~(w_statusWr & avs_s1_writedata[ST_OVF]));
            r_perr <= w_rxPerr | (r_perr & ~(w_statusWr & avs_s1_writedata[ST_PERR]));
            r_ferr <= w_rxFerr | (r_ferr & ~(w_statusWr & avs_s1_writedata[ST_FERR]));
            if (w_statusWr) begin
                r_irqEn <= avs_s1_writedata[ST_IRQ_EN];
            end
        end
    end

    // Last good scancode, updated even when the FIFO had to drop it
    always_ff @(posedge csi_clk) begin
        if (!csi_reset_n) begin
            r_last <= '0;
        end else if (w_rxValid) begin
            r_last <= w_rxByte;
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge csi_clk) begin
        if (!csi_reset_n) begin
            r_readData <= '0;
        end else if (avs_s1_read) begin
            case (avs_s1_address)
                ADDR_DATA:   r_readData <= w_notEmpty ? r_mem[r_rdPtr] : 8'h00;
                ADDR_STATUS: r_readData <= w_status;
                ADDR_LEVEL:  r_readData <= w_level;
                default:     r_readData <= r_last;
            endcase
        end
    end

    // Level interrupt, one cycle behind the conditions that raise it
    always_ff @(posedge csi_clk) begin
        if (!csi_reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irqEn & (w_notEmpty | r_ovf | r_perr | r_ferr);
        end
    end

    assign avs_s1_readdata = r_readData;
    assign ins_irq0_irq    = r_irq;
    assign coe_sseg0       = hex2seg(r_last[7:4]);
    assign coe_sseg1       = hex2seg(r_last[3:0]);

endmodule
